// File: rtl/led_grid_framebuffer_pkg.sv
// rtl/led_grid_framebuffer_pkg.sv - shared constants and FSM encoding for the LED grid framebuffer
package led_grid_framebuffer_pkg;

    localparam int NUM_COLS_DEFAULT = 5;
    localparam int COL_BITS_DEFAULT = 8;

    // Write-port address map
    localparam logic [2:0] ADDR_COL1   = 3'd0;
    localparam logic [2:0] ADDR_COL2   = 3'd1;
    localparam logic [2:0] ADDR_COL3   = 3'd2;
    localparam logic [2:0] ADDR_COL4   = 3'd3;
    localparam logic [2:0] ADDR_COL5   = 3'd4;
    localparam logic [2:0] ADDR_CLEAR  = 3'd5;
    localparam logic [2:0] ADDR_BLANK  = 3'd6;
    localparam logic [2:0] ADDR_COMMIT = 3'd7;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

endpackage

// File: rtl/led_grid_commit_fsm.sv
// rtl/led_grid_commit_fsm.sv - commit handshake: waits for frame_sync or timeout, then swaps
//
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   wr_en, wr_addr    processor write strobe and address (data not needed here)
//   frame_sync        scanner pulse marking column 1 active
//   busy              registered, high while a commit is pending
//   overflow          sticky, a write was dropped while pending
//   swap              one-cycle pulse; the parent copies back -> front on this edge
module led_grid_commit_fsm
    import led_grid_framebuffer_pkg::*;
#(
    parameter int SYNC_TIMEOUT = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic       frame_sync,
    output logic       busy,
    output logic       overflow,
    output logic       swap
);

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(SYNC_TIMEOUT);

    state_t     state;
    logic [7:0] timeout_cnt;

    // Decoded from registered state so the swap lands on the PENDING->IDLE edge itself,
    // making grid_values change one cycle after the qualifying frame_sync cycle.
    assign swap = (state == ST_PENDING) && (frame_sync || (timeout_cnt == TIMEOUT_LIMIT));

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            timeout_cnt <= 8'd0;
            busy        <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // frame_sync is ignored here, so commit+sync in one cycle waits for the next sync
                    if (wr_en && (wr_addr == ADDR_COMMIT)) begin
                        state       <= ST_PENDING;
                        busy        <= 1'b1;
                        timeout_cnt <= 8'd0;
                    end
                end
                ST_PENDING: begin
                    // Blank is always accepted; everything else is dropped, including a repeat commit
                    if (wr_en && (wr_addr != ADDR_BLANK)) begin
                        overflow <= 1'b1;
                    end
                    if (swap) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        timeout_cnt <= timeout_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/led_grid_framebuffer.sv
// rtl/led_grid_framebuffer.sv - double-buffered framebuffer feeding the 5x8 LED column driver
//
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data  processor write port (0..4 column, 5 clear, 6 blank, 7 commit)
//   frame_sync        scanner pulse when column 1 becomes active
//   grid_values       front buffer, [39:32] = column 1 ... [7:0] = column 5
//   grid_ready        front buffer valid
//   busy, overflow    commit pending / sticky dropped-write flag
//   frame_count       completed swaps, wraps mod 256
module led_grid_framebuffer
    import led_grid_framebuffer_pkg::*;
#(
    parameter int NUM_COLS     = NUM_COLS_DEFAULT,
    parameter int COL_BITS     = COL_BITS_DEFAULT,
    parameter int SYNC_TIMEOUT = 255
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [2:0]                   wr_addr,
    input  logic [COL_BITS-1:0]          wr_data,
    input  logic                         frame_sync,
    output logic [NUM_COLS*COL_BITS-1:0] grid_values,
    output logic                         grid_ready,
    output logic                         busy,
    output logic                         overflow,
    output logic [7:0]                   frame_count
);

    logic [NUM_COLS*COL_BITS-1:0] back_buf;
    logic                         swap;

    led_grid_commit_fsm #(
        .SYNC_TIMEOUT(SYNC_TIMEOUT)
    ) u_commit_fsm (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .frame_sync (frame_sync),
        .busy       (busy),
        .overflow   (overflow),
        .swap       (swap)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            back_buf    <= '0;
            grid_values <= '0;
            grid_ready  <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            // Back-buffer edits only while idle; busy mirrors the FSM state exactly
            if (wr_en && !busy) begin
                if (wr_addr <= ADDR_COL5) begin
                    // Column 1 sits in the most significant byte
                    back_buf[(NUM_COLS - 1 - int'(wr_addr)) * COL_BITS +: COL_BITS] <= wr_data;
                end else if (wr_addr == ADDR_CLEAR) begin
                    back_buf <= '0;
                end
            end
            if (wr_en && (wr_addr == ADDR_BLANK)) begin
                grid_ready <= 1'b0;
            end
            // Placed last so a swap re-raises grid_ready even if a blank lands in the same cycle
            if (swap) begin
                grid_values <= back_buf;
                grid_ready  <= 1'b1;
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_led_grid_framebuffer.sv
// tb/tb_led_grid_framebuffer.sv - directed self-checking bench for led_grid_framebuffer
module tb_led_grid_framebuffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        frame_sync;
    logic [39:0] grid_values;
    logic        grid_ready;
    logic        busy;
    logic        overflow;
    logic [7:0]  frame_count;

    int checks   = 0;
    int failures = 0;

    led_grid_framebuffer dut (
        .clock       (clock),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_sync  (frame_sync),
        .grid_values (grid_values),
        .grid_ready  (grid_ready),
        .busy        (busy),
        .overflow    (overflow),
        .frame_count (frame_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive at a negedge, capture on the following posedge, return at the next negedge
    task automatic wr(input logic [2:0] addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(negedge clock);
        wr_en   = 1'b0;
        wr_data = 8'h00;
    endtask

    task automatic pulse_sync();
        frame_sync = 1'b1;
        @(negedge clock);
        frame_sync = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = 3'd0;
        wr_data    = 8'h00;
        frame_sync = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        check("rst_grid", 64'(grid_values), 64'h0);
        check("rst_ready", 64'(grid_ready), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_fc", 64'(frame_count), 64'h0);
        check("rst_ovf", 64'(overflow), 64'h0);

        // Box pattern, commit, sync ten cycles later
        wr(3'd0, 8'hFF);
        wr(3'd1, 8'h81);
        wr(3'd2, 8'h81);
        wr(3'd3, 8'h81);
        wr(3'd4, 8'hFF);
        wr(3'd7, 8'h00);
        check("commit_busy", 64'(busy), 64'h1);
        repeat (9) @(negedge clock);
        frame_sync = 1'b1;
        check("pre_swap_grid", 64'(grid_values), 64'h0);
        @(negedge clock);
        frame_sync = 1'b0;
        check("swap1_grid", 64'(grid_values), 64'hFF818181FF);
        check("swap1_ready", 64'(grid_ready), 64'h1);
        check("swap1_fc", 64'(frame_count), 64'h1);
        check("swap1_busy", 64'(busy), 64'h0);

        // Write while busy is dropped and flags overflow
        wr(3'd7, 8'h00);
        wr(3'd0, 8'h55);
        check("drop_ovf", 64'(overflow), 64'h1);
        pulse_sync();
        check("drop_grid", 64'(grid_values), 64'hFF818181FF);
        check("drop_fc", 64'(frame_count), 64'h2);

        // Commit and frame_sync in the same idle cycle: no swap until the next sync
        wr(3'd4, 8'h3C);
        frame_sync = 1'b1;
        wr(3'd7, 8'h00);
        frame_sync = 1'b0;
        check("same_busy", 64'(busy), 64'h1);
        check("same_fc", 64'(frame_count), 64'h2);
        check("same_grid", 64'(grid_values), 64'hFF818181FF);
        repeat (2) @(negedge clock);
        check("same_wait_busy", 64'(busy), 64'h1);
        pulse_sync();
        check("same_grid2", 64'(grid_values), 64'hFF8181813C);
        check("same_fc2", 64'(frame_count), 64'h3);

        // Forced swap with frame_sync held low: lands 256 cycles after the commit edge
        wr(3'd2, 8'h18);
        wr(3'd7, 8'h00);
        repeat (255) @(negedge clock);
        check("to_pre_grid", 64'(grid_values), 64'hFF8181813C);
        check("to_pre_busy", 64'(busy), 64'h1);
        @(negedge clock);
        check("to_grid", 64'(grid_values), 64'hFF8118813C);
        check("to_busy", 64'(busy), 64'h0);
        check("to_fc", 64'(frame_count), 64'h4);

        // Blank keeps front contents, then clear + commit yields an empty lit frame
        wr(3'd6, 8'h00);
        check("blank_ready", 64'(grid_ready), 64'h0);
        check("blank_grid", 64'(grid_values), 64'hFF8118813C);
        wr(3'd5, 8'h00);
        check("clear_front_kept", 64'(grid_values), 64'hFF8118813C);
        wr(3'd7, 8'h00);
        pulse_sync();
        check("clear_grid", 64'(grid_values), 64'h0);
        check("clear_ready", 64'(grid_ready), 64'h1);
        check("clear_fc", 64'(frame_count), 64'h5);

        // Blank while pending: swap re-raises grid_ready
        wr(3'd7, 8'h00);
        wr(3'd6, 8'h00);
        check("pblank_ready", 64'(grid_ready), 64'h0);
        check("pblank_busy", 64'(busy), 64'h1);
        pulse_sync();
        check("pblank_ready2", 64'(grid_ready), 64'h1);
        check("pblank_fc", 64'(frame_count), 64'h6);

        // Run swaps until frame_count wraps
        for (int i = 0; i < 249; i++) begin
            wr(3'd7, 8'h00);
            pulse_sync();
        end
        check("wrap_255", 64'(frame_count), 64'hFF);
        wr(3'd7, 8'h00);
        pulse_sync();
        check("wrap_0", 64'(frame_count), 64'h0);
        check("ovf_sticky", 64'(overflow), 64'h1);

        // Reset mid-pending abandons the commit
        wr(3'd0, 8'hAA);
        wr(3'd7, 8'h00);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst2_busy", 64'(busy), 64'h0);
        check("rst2_ovf", 64'(overflow), 64'h0);
        check("rst2_grid", 64'(grid_values), 64'h0);
        pulse_sync();
        check("rst2_fc", 64'(frame_count), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_grid_framebuffer.md
Name: led_grid_framebuffer

Overview:
- Sits upstream of the 5x8 LED-matrix column driver in the top-level skeleton; produces the 40-bit grid_values word and grid_ready qualifier that the driver scans.
- Processor writes column bytes into a back buffer via a memory-mapped write port, then issues a commit.
- Back buffer is copied to the displayed front buffer only on the scanner's frame boundary, so the display never shows a partially updated frame.

Parameters:
- NUM_COLS, 5, number of matrix columns
- COL_BITS, 8, LEDs (rows) per column
- SYNC_TIMEOUT, 255, cycles to wait for frame_sync before forcing the swap

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  processor write strobe, one cycle per write
- wr_addr  in  3  0..4 = column 1..5 byte; 5 = clear back buffer; 6 = blank display; 7 = commit
- wr_data  in  8  column byte; bit 7 = row 1 (top) ... bit 0 = row 8; ignored for addr 5..7
- frame_sync  in  1  one-cycle pulse from scanner when column 1 becomes active
- grid_values  out  40  front buffer; [39:32] = col 1 ... [7:0] = col 5
- grid_ready  out  1  front buffer valid; driver blanks when low
- busy  out  1  commit pending
- overflow  out  1  sticky: a write was dropped while busy
- frame_count  out  8  number of completed swaps, wraps 255 -> 0

Behaviour:
- Reset, synchronous and active-high: back and front buffers = 0, grid_ready = 0, busy = 0, overflow = 0, frame_count = 0, FSM = IDLE. Reset mid-PENDING abandons the commit.
- FSM states:
  - IDLE -> PENDING on a commit write (addr 7); timeout counter loads 0.
  - PENDING -> IDLE on frame_sync, or when the timeout counter reaches SYNC_TIMEOUT.
- busy = (state == PENDING), registered.
- Column write (addr 0..4) in IDLE: back[col] <= wr_data on the next edge.
- Clear (addr 5) in IDLE: back buffer <= 0; front buffer unchanged.
- Blank (addr 6), accepted in either state:
  - grid_ready <= 0 next edge; front buffer unchanged.
  - In PENDING it does not cancel the commit; the swap re-raises grid_ready.
- Any write with addr 0..5 or 7 while PENDING is dropped, and overflow <= 1. A repeated commit also sets overflow and does not restart the timeout.
- Swap, on the PENDING->IDLE edge:
  - front <= back; grid_ready <= 1; frame_count <= frame_count + 1 (mod 256).
  - grid_values changes exactly one cycle after the qualifying frame_sync cycle.
- frame_sync is only sampled in PENDING. A commit write and frame_sync in the same IDLE cycle do not swap: the FSM enters PENDING and waits for the next frame_sync.
- Timeout counter is 8 bits. It increments each PENDING cycle without frame_sync. The forced swap happens on the cycle the counter equals SYNC_TIMEOUT, i.e. SYNC_TIMEOUT+1 cycles after entering PENDING. This guarantees progress if the scanner is stalled.
- overflow clears only on reset.
- Back buffer contents persist after a swap, so incremental updates need only the changed columns.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package holds:
  - Address constants: ADDR_COL1..ADDR_COL5 = 0..4, ADDR_CLEAR = 5, ADDR_BLANK = 6, ADDR_COMMIT = 7.
  - FSM state encoding: IDLE = 0, PENDING = 1.
  - NUM_COLS and COL_BITS defaults.
- One natural sub-module: led_grid_commit_fsm, holding the state, timeout counter and busy/overflow logic. It emits a one-cycle swap pulse to the buffer datapath in the parent.

Test Plan:
- Reset -> grid_values = 0, grid_ready = 0, busy = 0, frame_count = 0.
- Write cols 0xFF, 0x81, 0x81, 0x81, 0xFF, then commit, then frame_sync 10 cycles later -> one cycle after frame_sync: grid_values = 40'hFF818181FF, grid_ready = 1, frame_count = 1, busy = 0.
- Commit, then write col1 = 0x55 while busy -> write dropped, overflow = 1. After frame_sync, col1 of grid_values keeps its pre-commit back-buffer value.
- Commit and frame_sync in the same cycle -> no swap that cycle, busy = 1; swap only on the following frame_sync pulse.
- Commit with frame_sync held low -> forced swap with grid_values updated exactly SYNC_TIMEOUT+1 = 256 cycles after the commit edge; frame_count increments.
- Blank after a valid frame -> grid_ready = 0, grid_values unchanged. Then clear, commit, frame_sync -> grid_values = 0, grid_ready = 1. Also run 256 swaps -> frame_count wraps to 0.
